// File: rtl/imem_loader.sv
// imem_loader: packs a little-endian byte stream into 32-bit words and writes
// them to the instruction memory from byte address 0. The processor is held in
// reset (cpu_hold) while a load is in progress.
module imem_loader #(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W:0]   num_words,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              we,
  output logic [31:0]       wa,
  output logic [31:0]       wd,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(1) << ADDR_W;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [1:0]          r_byte_idx;
  logic [ADDR_W-1:0]   r_word_idx;
  logic [ADDR_W:0]     r_target;
  logic [31:0]         r_shift;
  logic [31:0]         r_wa;
  logic [31:0]         r_wd;
  logic                r_err;

  logic                w_xfer;
  logic                w_start_ok;
  logic                w_too_big;
  logic                w_last_word;
  logic [31:0]         w_word;

  // Handshake and start qualification; start is only honoured in IDLE/DONE.
  always_comb begin
    w_xfer      = byte_valid && (r_state == S_LOAD);
    w_start_ok  = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    w_too_big   = (num_words > DEPTH);
    w_last_word = (({1'b0, r_word_idx} + (ADDR_W+1)'(1)) == r_target);
    w_word      = r_shift;
    w_word[{r_byte_idx, 3'b000} +: 8] = byte_data;
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (w_start_ok && !w_too_big) begin
          w_state_nxt = (num_words == (ADDR_W+1)'(0)) ? S_DONE : S_LOAD;
        end else begin
          w_state_nxt = r_state;
        end
      end
      S_LOAD: begin
        if (w_xfer && (r_byte_idx == 2'd3)) begin
          w_state_nxt = S_WRITE;
        end else begin
          w_state_nxt = S_LOAD;
        end
      end
      S_WRITE: begin
        if (w_last_word) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_LOAD;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath: byte packing, word counter, latched write address/data, error flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_byte_idx <= 2'd0;
      r_word_idx <= '0;
      r_target   <= '0;
      r_shift    <= 32'd0;
      r_wa       <= 32'd0;
      r_wd       <= 32'd0;
      r_err      <= 1'b0;
    end else begin
      if (w_start_ok) begin
        r_err <= w_too_big;
        if (!w_too_big) begin
          r_target   <= num_words;
          r_word_idx <= '0;
          r_byte_idx <= 2'd0;
        end
      end
      if (w_xfer) begin
        r_shift    <= w_word;
        r_byte_idx <= r_byte_idx + 2'd1;
        if (r_byte_idx == 2'd3) begin
          // Capture the completed word so wa/wd are valid during WRITE and
          // hold afterwards.
          r_wd <= w_word;
          r_wa <= 32'({r_word_idx, 2'b00});
        end
      end
      if ((r_state == S_WRITE) && !w_last_word) begin
        r_word_idx <= r_word_idx + ADDR_W'(1);
      end
    end
  end

  // Output decode (Moore outputs from the state register).
  always_comb begin
    byte_ready = 1'b0;
    we         = 1'b0;
    cpu_hold   = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (r_state)
      S_IDLE:  begin end
      S_LOAD:  begin byte_ready = 1'b1; cpu_hold = 1'b1; busy = 1'b1; end
      S_WRITE: begin we = 1'b1; cpu_hold = 1'b1; busy = 1'b1; end
      S_DONE:  begin done = 1'b1; end
      default: begin end
    endcase
    wa  = r_wa;
    wd  = r_wd;
    err = r_err;
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: a byte-packing model pushes expected
// writes to a queue; a monitor pops and compares on every we pulse.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [6:0]  num_words;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready, we, cpu_hold, busy, done, err;
  logic [31:0] wa, wd;

  int n_chk = 0;
  int n_err = 0;
  int n_we  = 0;

  logic [63:0] exp_q[$];
  logic [31:0] m_word;
  logic [31:0] m_wa;
  int          m_idx;

  imem_loader #(.ADDR_W(6)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .num_words(num_words),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .we(we), .wa(wa), .wd(wd), .cpu_hold(cpu_hold), .busy(busy),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Monitor: every write pulse is checked against the scoreboard.
  always @(negedge clk) begin
    if (reset_n && we) begin
      n_we++;
      check_val("ready_in_we", {31'd0, byte_ready}, 32'd0);
      if (exp_q.size() == 0) begin
        check_val("unexpected_we", 32'd1, 32'd0);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        check_val("wa", wa, e[63:32]);
        check_val("wd", wd, e[31:0]);
      end
    end
  end

  task automatic model_reset();
    m_word = 32'd0; m_wa = 32'd0; m_idx = 0;
  endtask

  task automatic model_feed(input logic [7:0] b);
    m_word[8*m_idx +: 8] = b;
    m_idx++;
    if (m_idx == 4) begin
      exp_q.push_back({m_wa, m_word});
      m_wa  = m_wa + 32'd4;
      m_idx = 0;
    end
  endtask

  // Called at a negedge; returns at a negedge.
  task automatic pulse_start(input logic [6:0] n);
    start = 1'b1; num_words = n;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t = 0;
    byte_valid = 1'b1; byte_data = b;
    while (!byte_ready && t < 50) begin
      @(negedge clk); t++;
    end
    if (t >= 50) check_val("byte_timeout", 32'd1, 32'd0);
    model_feed(b);
    @(negedge clk);
    byte_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic wait_done();
    int t = 0;
    while (!done && t < 100) begin
      @(negedge clk); t++;
    end
    check_val("done", {31'd0, done}, 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    exp_q.delete();
    @(negedge clk);
  endtask

  logic [7:0] prog [12] = '{8'h0A, 8'h00, 8'hA0, 8'hE3, 8'h05, 8'h10,
                            8'hA0, 8'hE3, 8'h01, 8'h00, 8'h80, 8'hE0};
  logic [7:0] w1 [4]   = '{8'h78, 8'h56, 8'h34, 8'h12};
  int we0;

  initial begin
    reset_n = 1'b0; start = 1'b0; num_words = 7'd0;
    byte_valid = 1'b0; byte_data = 8'd0;
    model_reset();
    #12;
    check_val("rst_outs", {26'd0, byte_ready, we, cpu_hold, busy, done, err}, 32'd0);
    check_val("rst_wa", wa, 32'd0);
    check_val("rst_wd", wd, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Three words, continuous stream.
    model_reset(); we0 = n_we;
    pulse_start(7'd3);
    check_val("hold_load", {30'd0, cpu_hold, busy}, 32'd3);
    for (int i = 0; i < 12; i++) send_byte(prog[i], 0);
    wait_done();
    check_val("t1_we_cnt", 32'(n_we - we0), 32'd3);
    check_val("t1_idle_outs", {30'd0, cpu_hold, busy}, 32'd0);
    check_val("t1_wd_hold", wd, 32'hE0800001);

    // Same program, byte_valid toggling; started from DONE.
    model_reset(); we0 = n_we;
    pulse_start(7'd3);
    check_val("t2_done_clr", {31'd0, done}, 32'd0);
    for (int i = 0; i < 12; i++) send_byte(prog[i], 1);
    wait_done();
    check_val("t2_we_cnt", 32'(n_we - we0), 32'd3);

    // Oversize request from IDLE, then a valid single word.
    do_reset();
    we0 = n_we;
    pulse_start(7'd65);
    repeat (3) @(negedge clk);
    check_val("t3_err", {31'd0, err}, 32'd1);
    check_val("t3_idle", {28'd0, byte_ready, busy, done, cpu_hold}, 32'd0);
    check_val("t3_no_we", 32'(n_we - we0), 32'd0);
    model_reset();
    pulse_start(7'd1);
    check_val("t3_err_clr", {31'd0, err}, 32'd0);
    for (int i = 0; i < 4; i++) send_byte(w1[i], 0);
    wait_done();
    check_val("t3_we_cnt", 32'(n_we - we0), 32'd1);

    // Zero-length load.
    do_reset();
    we0 = n_we;
    pulse_start(7'd0);
    check_val("t4_done", {31'd0, done}, 32'd1);
    check_val("t4_hold", {30'd0, cpu_hold, busy}, 32'd0);
    repeat (3) @(negedge clk);
    check_val("t4_no_we", 32'(n_we - we0), 32'd0);

    // Ignored start mid-load, then asynchronous reset.
    do_reset();
    model_reset(); we0 = n_we;
    pulse_start(7'd2);
    for (int i = 0; i < 6; i++) send_byte(prog[i], 0);
    pulse_start(7'd1);
    check_val("t5_busy", {31'd0, busy}, 32'd1);
    check_val("t5_we_cnt", 32'(n_we - we0), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check_val("t5_rst_outs", {26'd0, byte_ready, we, cpu_hold, busy, done, err}, 32'd0);
    check_val("t5_rst_wa", wa, 32'd0);
    check_val("t5_rst_wd", wd, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    exp_q.delete();
    @(negedge clk);
    model_reset(); we0 = n_we;
    pulse_start(7'd1);
    send_byte(8'hAA, 0); send_byte(8'hBB, 0); send_byte(8'hCC, 0); send_byte(8'hDD, 0);
    wait_done();
    check_val("t5_reload_cnt", 32'(n_we - we0), 32'd1);

    // Full depth with incrementing bytes.
    model_reset(); we0 = n_we;
    pulse_start(7'd64);
    for (int i = 0; i < 256; i++) send_byte(8'(i), 0);
    wait_done();
    check_val("t6_we_cnt", 32'(n_we - we0), 32'd64);
    check_val("t6_last_wa", wa, 32'h000000FC);
    check_val("t6_last_wd", wd, 32'hFFFEFDFC);
    check_val("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
